// File: rtl/sixteen_bit_adder_pkg.sv
// Shared types for the 16-bit ripple adder and the 32-bit datapath that
// chains two of them.
package sixteen_bit_adder_pkg;

  localparam int ADD_WIDTH = 16;

  typedef logic [15:0] word_t;

  typedef struct packed {
    word_t sum;
    logic  cout;
  } add_result_t;

endpackage

// File: rtl/sixteen_bit_adder_full_adder.sv
// Single-bit full-adder cell; the unit of the ripple chain.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/sixteen_bit_adder.sv
// Registered 16-bit ripple-carry adder with carry in/out.
// Define SIXTEEN_BIT_ADDER_OVF_EN to add the registered signed-overflow port ovf.
module sixteen_bit_adder
  import sixteen_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  assign c[0] = cin;

  // Carry ripples LSB to MSB through the cell chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = s;
      cout_d      = c[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef SIXTEEN_BIT_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder.
// Honours SIXTEEN_BIT_ADDER_OVF_EN when defined.
module tb_sixteen_bit_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  sixteen_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t ref_add(logic [15:0] x, logic [15:0] y,
                                   logic ci);
    exp_t        e;
    logic [16:0] r;
    logic [15:0] lo;
    r     = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    lo    = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'd0, ci};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = r[16] ^ lo[15];
    return e;
  endfunction

  task automatic drive(logic v, logic [15:0] x, logic [15:0] y,
                       logic ci);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    if (v && rst_n) sb.push_back(ref_add(x, y, ci));
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sum, cout, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset[%0d] got sum=%h cout=%b ov=%b want 0000/0/0",
                 i, sum, cout, out_valid);
      end
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
        failures++;
        $display("FAIL reset_ovf got %b want 0", ovf);
      end
`endif
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_vectors(string name, logic [15:0] xs[],
                              logic [15:0] ys[], logic cs[]);
    exp_t e;
    for (int i = 0; i < xs.size(); i++) begin
      drive(1'b1, xs[i], ys[i], cs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({sum, cout, out_valid} !== {e.sum, e.cout, 1'b1}) begin
        failures++;
        $display("FAIL %s[%0d] got %h/%b/%b want %h/%b/1", name, i,
                 sum, cout, out_valid, e.sum, e.cout);
      end
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
      checks++;
      if (ovf !== e.ovf) begin
        failures++;
        $display("FAIL %s_ovf[%0d] got %b want %b", name, i, ovf, e.ovf);
      end
`endif
    end
  endtask

  task automatic test_basic();
    test_vectors("zero",  '{16'h0000}, '{16'h0000}, '{1'b0});
    test_vectors("ones",  '{16'hFFFF}, '{16'hFFFF}, '{1'b1});
    test_vectors("ripple", '{16'hAAAA, 16'hFFFF},
                 '{16'hFFFF, 16'h0000}, '{1'b1, 1'b1});
  endtask

  task automatic test_hold();
    test_vectors("cap", '{16'h1234}, '{16'h4321}, '{1'b0});
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sum, cout, out_valid} !== {16'h5555, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold[%0d] got %h/%b/%b want 5555/0/0",
                 i, sum, cout, out_valid);
      end
    end
  endtask

  task automatic test_signed();
    exp_t e;
    e = ref_add(16'h7FFF, 16'h0001, 1'b0);
    checks++;
    if ({e.sum, e.cout, e.ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL model_signed got %h/%b/%b want 8000/0/1",
               e.sum, e.cout, e.ovf);
    end
    test_vectors("signed", '{16'h7FFF, 16'h8000, 16'hFFFF},
                 '{16'h0001, 16'h8000, 16'h0001}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic rst_seen = 1'b0;
    sb.delete();
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (rst_seen) begin
        checks++;
        if ({sum, cout, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL midrst got %h/%b/%b want 0000/0/0",
                   sum, cout, out_valid);
        end
        rst_seen = 1'b0;
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({sum, cout, out_valid} !== {e.sum, e.cout, 1'b1}) begin
          failures++;
          $display("FAIL rand[%0d] got %h/%b/%b want %h/%b/1", i,
                   sum, cout, out_valid, e.sum, e.cout);
        end
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
          failures++;
          $display("FAIL rand_ovf[%0d] got %b want %b", i, ovf, e.ovf);
        end
`endif
      end
      if (i == 10000) begin
        in_valid = 1'b0;
        break;
      end
      rst_n    = (i != 5000);
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom);
      if (rst_n) sb.push_back(ref_add(a, b, cin));
      else rst_seen = 1'b1;
    end
    rst_n = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_signed();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
